ltsm_hs_sequencer: RTL and testbench
====================================

# ltsm_hs_sequencer

- Parametrised successor to the fixed six-step MBINIT sideband sequencer.
- Drives `NUM_STAGES` consecutive req/resp sideband handshakes with the link partner, one per LTSM sub-state.
- Advances a stage only when both sides have exchanged responses; includes a built-in retry/timeout timer.
- Sits between an LTSM state (MBINIT, MBTRAIN, …) and the SB TX/RX message queues on the 100 MHz sideband clock.

## Interface
Parameters:
- NUM_STAGES, 6, number of handshake stages (2..16)
- MSG_W, 8, msg_num width
- MSG_BASE, 8'h40, stage s req code = MSG_BASE+2s, resp code = MSG_BASE+2s+1
- WAKEUP_CYCLES, 2, delay from enable rise to first req
- TIMEOUT_CYCLES, 1024, cycles without stage progress before retry/error
- MAX_RETRIES, 3, req resends allowed per stage

Ports:
- clk_100MHz  in  1  sole clock
- reset  in  1  asynchronous, active-high
- enable_i  in  1  low = synchronous return to IDLE, all state cleared
- done_o  out  1  sticky, all stages complete
- error_o  out  1  sticky, timeout exhausted
- stage_o  out  $clog2(NUM_STAGES)  current stage index
- SB_TX_msg_num_o  out  MSG_W  message code offered
- SB_TX_msg_valid_o  out  1  offer valid
- SB_TX_msg_sendNextFlag_i  in  1  TX queue accepts while valid
- SB_RX_msg_num_i  in  MSG_W  received code
- SB_RX_msg_available_i  in  1  RX queue non-empty
- SB_RX_msg_req_o  out  1  pop pulse
- SB_RX_msg_valid_i  in  1  popped message valid, one cycle after req
- reset_state_timeout_counter_o  out  1  one-cycle pulse on every stage advance

## Operation
States:
- IDLE: entered on reset or enable low.
- WAKE: counts WAKEUP_CYCLES, then queues req(0) and moves to RUN.
- RUN: normal handshake operation.
- DONE: entered when the last stage completes; done_o=1.
- ERROR: error_o=1; no further TX.

Per-stage flags, cleared on advance:
- rx_req_seen, rx_resp_seen, tx_resp_sent.
- req_pend, resp_pend: TX pending slots.

RX path:
- SB_RX_msg_req_o pulses when available=1, not in IDLE, and no pop outstanding.
- On SB_RX_msg_valid_i, decode the code:
  - req(stage): set rx_req_seen and resp_pend. A duplicate req re-queues the resp.
  - resp(stage): set rx_resp_seen.
  - req(stage+1): set early_req; on advance this becomes rx_req_seen and resp_pend.
  - Anything else: dropped, no effect.

TX path:
- One offer register. resp_pend has priority over req_pend.
- Offer is loaded only when SB_TX_msg_valid_o=0.
- Handshake completes on a cycle with valid=1 and sendNextFlag=1; the slot clears next cycle.
- A completed resp(stage) sets tx_resp_sent.

Advance:
- Condition: rx_resp_seen && tx_resp_sent in RUN.
- stage+1, flags cleared, req_pend=1, timer and retry count cleared, reset_state_timeout_counter_o pulse.
- At stage NUM_STAGES-1, go to DONE instead. Pending resp offers are still drained in DONE.

Timer:
- Counts in RUN while the stage has not advanced.
- Reaching TIMEOUT_CYCLES-1 applies the expiry action (see Configuration).

Simultaneous events:
- RX decode and TX completion in the same cycle both take effect.
- Advance wins over timer expiry in the same cycle.

Reset and enable:
- Reset or enable low mid-operation: offer dropped (valid=0 next cycle), stage 0, done/error cleared.

## Timing
- Reset values: all outputs 0, stage_o=0.
- Enable rise at edge E: SB_TX_msg_valid_o=1 with req(0) after edge E+WAKEUP_CYCLES+1.
- rx valid sampled at edge E (req received): resp offered after edge E+1, i.e. two-cycle response latency.
- SB_RX_msg_req_o: one cycle wide. The next pop is allowed the cycle after valid is seen.
- SB_TX_msg_valid_o holds with a stable code until accepted.
- Timer width: $clog2(TIMEOUT_CYCLES)+1. The retry counter saturates at MAX_RETRIES.

## Configuration
Macro: LTSM_HS_RETRY_EN

With the macro defined, on timer expiry:
- If rx_resp_seen=0 and retries<MAX_RETRIES: re-queue req(stage), retries+1, timer cleared.
- Otherwise: go to ERROR.

Without the macro:
- Expiry goes straight to ERROR. The retry counter is not built.

## Test plan
- **Clean run**: NUM_STAGES=6, partner echoes req then resp for codes 0x40..0x4B → stage_o steps 0..5, six reset_state_timeout_counter_o pulses, done_o=1, error_o=0.
- **Crossed reqs**: partner sends req(0) before our req(0) is accepted → resp 0x41 offered after our req 0x40, stage advances only after 0x41 is accepted and 0x41 is received.
- **Early next req**: resp(2)=0x45 and req(3)=0x46 popped back-to-back → stage_o=3 and 0x47 sent without a re-received req.
- **Backpressure**: sendNextFlag held 0 for 10 cycles → valid and code stay stable, no lost or duplicated message.
- **Retry** (macro on, TIMEOUT_CYCLES=16, MAX_RETRIES=2): silent partner → req(0) sent 3 times 16 cycles apart, then error_o=1. With the macro off → error_o=1 after 16 cycles, single req.
- **Abort**: enable low at stage 3 → next cycle valid=0, stage_o=0, done_o=0. Enable high again → 0x40 resent after WAKEUP_CYCLES+1.

Source files
------------

// File: rtl/ltsm_hs_sequencer_if.sv
// Sideband message-queue bundle between the LTSM handshake sequencer
// (master) and the SB TX/RX message queues (slave).
interface ltsm_hs_sequencer_if #(
  parameter int MSG_W = 8
);
  logic [MSG_W-1:0] SB_TX_msg_num_o;
  logic             SB_TX_msg_valid_o;
  logic             SB_TX_msg_sendNextFlag_i;
  logic [MSG_W-1:0] SB_RX_msg_num_i;
  logic             SB_RX_msg_available_i;
  logic             SB_RX_msg_req_o;
  logic             SB_RX_msg_valid_i;

  modport master (
    output SB_TX_msg_num_o, SB_TX_msg_valid_o, SB_RX_msg_req_o,
    input  SB_TX_msg_sendNextFlag_i, SB_RX_msg_num_i,
           SB_RX_msg_available_i, SB_RX_msg_valid_i
  );

  modport slave (
    input  SB_TX_msg_num_o, SB_TX_msg_valid_o, SB_RX_msg_req_o,
    output SB_TX_msg_sendNextFlag_i, SB_RX_msg_num_i,
           SB_RX_msg_available_i, SB_RX_msg_valid_i
  );
endinterface

// File: rtl/ltsm_hs_sequencer.sv
// ltsm_hs_sequencer: runs NUM_STAGES req/resp sideband handshakes with the
// link partner. Stage s uses req = MSG_BASE+2s, resp = MSG_BASE+2s+1; a stage
// advances once the partner's resp is received and our resp is sent.
// Optional feature macro: LTSM_HS_RETRY_EN -- on timeout, resend req(stage)
// up to MAX_RETRIES times before flagging error (default: error at once).
module ltsm_hs_sequencer #(
  parameter int               NUM_STAGES     = 6,
  parameter int               MSG_W          = 8,
  parameter logic [MSG_W-1:0] MSG_BASE       = MSG_W'(8'h40),
  parameter int               WAKEUP_CYCLES  = 2,
  parameter int               TIMEOUT_CYCLES = 1024,
  parameter int               MAX_RETRIES    = 3
) (
  input  logic                          clk_100MHz,
  input  logic                          reset,
  input  logic                          enable_i,
  output logic                          done_o,
  output logic                          error_o,
  output logic [$clog2(NUM_STAGES)-1:0] stage_o,
  output logic                          reset_state_timeout_counter_o,
  ltsm_hs_sequencer_if.master           sb
);
  localparam int SW = $clog2(NUM_STAGES);
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int WW = $clog2(WAKEUP_CYCLES + 1) + 1;
  localparam int RW = $clog2(MAX_RETRIES + 1) + 1;

  typedef enum logic [2:0] {S_IDLE, S_WAKE, S_RUN, S_DONE, S_ERROR} state_t;

  // All sequencer state; zero is the idle/cleared value for every field so
  // reset and enable-low share one clear.
  typedef struct packed {
    state_t           state;
    logic [SW-1:0]    stage;
    logic [WW-1:0]    wake;
    logic [TW-1:0]    timer;
    logic             rx_req_seen;
    logic             rx_resp_seen;
    logic             tx_resp_sent;
    logic             early_req;
    logic             req_pend;
    logic             resp_pend;
    logic             tx_valid;
    logic [MSG_W-1:0] tx_num;
    logic             rx_req;
    logic             pop_out;
    logic             pulse;
    logic             done;
    logic             err;
  } seq_t;

  seq_t r_s;

  logic [MSG_W-1:0] w_req_code, w_resp_code, w_nxt_code;
  logic w_last, w_live, w_rx_req, w_rx_resp, w_rx_nxt;
  logic w_tx_fire, w_advance, w_expire, w_retry;

  assign w_req_code  = MSG_BASE + (MSG_W'(r_s.stage) << 1);
  assign w_resp_code = w_req_code + MSG_W'(1);
  assign w_nxt_code  = w_req_code + MSG_W'(2);
  assign w_last      = (r_s.stage == SW'(NUM_STAGES - 1));

  // Popped messages are only meaningful once the sequence is running
  assign w_live    = (r_s.state == S_WAKE) || (r_s.state == S_RUN) || (r_s.state == S_DONE);
  assign w_rx_req  = w_live && sb.SB_RX_msg_valid_i && (sb.SB_RX_msg_num_i == w_req_code);
  assign w_rx_resp = w_live && sb.SB_RX_msg_valid_i && (sb.SB_RX_msg_num_i == w_resp_code);
  assign w_rx_nxt  = w_live && sb.SB_RX_msg_valid_i && !w_last && (sb.SB_RX_msg_num_i == w_nxt_code);

  assign w_tx_fire = r_s.tx_valid && sb.SB_TX_msg_sendNextFlag_i;
  assign w_advance = (r_s.state == S_RUN) && r_s.rx_resp_seen && r_s.tx_resp_sent;
  assign w_expire  = (r_s.state == S_RUN) && (r_s.timer == TW'(TIMEOUT_CYCLES - 1));

`ifdef LTSM_HS_RETRY_EN
  logic [RW-1:0] r_retries;

  // Only retry while the partner's resp is still missing
  assign w_retry = !r_s.rx_resp_seen && (r_retries < RW'(MAX_RETRIES));

  // Per-stage retry budget, refilled on every advance
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset)                        r_retries <= '0;
    else if (!enable_i || w_advance)  r_retries <= '0;
    else if (w_expire && w_retry)     r_retries <= r_retries + RW'(1);
  end
`else
  assign w_retry = 1'b0;
`endif

  // Sequencer FSM plus RX pop, TX offer slot and per-stage flags
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_s <= '0;
    end else if (!enable_i) begin
      r_s <= '0;
    end else begin
      r_s.pulse <= 1'b0;

      // RX: one-cycle pop; next pop allowed once the popped data shows up
      if (r_s.rx_req)
        r_s.rx_req <= 1'b0;
      else if (sb.SB_RX_msg_available_i && (r_s.state != S_IDLE) &&
               (!r_s.pop_out || sb.SB_RX_msg_valid_i)) begin
        r_s.rx_req  <= 1'b1;
        r_s.pop_out <= 1'b1;
      end else if (sb.SB_RX_msg_valid_i)
        r_s.pop_out <= 1'b0;

      // TX: single offer slot, resp before req, refilled only when empty
      if (w_tx_fire)
        r_s.tx_valid <= 1'b0;
      else if (!r_s.tx_valid) begin
        if (r_s.resp_pend && ((r_s.state == S_RUN) || (r_s.state == S_DONE))) begin
          r_s.tx_valid  <= 1'b1;
          r_s.tx_num    <= w_resp_code;
          r_s.resp_pend <= 1'b0;
        end else if (r_s.req_pend && (r_s.state == S_RUN)) begin
          r_s.tx_valid <= 1'b1;
          r_s.tx_num   <= w_req_code;
          r_s.req_pend <= 1'b0;
        end
      end
      if (w_tx_fire && (r_s.tx_num == w_resp_code)) r_s.tx_resp_sent <= 1'b1;

      // RX decode against the current stage; a duplicate req re-queues resp
      if (w_rx_req) begin
        r_s.rx_req_seen <= 1'b1;
        r_s.resp_pend   <= 1'b1;
      end
      if (w_rx_resp) r_s.rx_resp_seen <= 1'b1;
      if (w_rx_nxt)  r_s.early_req    <= 1'b1;

      case (r_s.state)
        S_IDLE: begin
          r_s.state <= S_WAKE;
          r_s.wake  <= '0;
        end
        S_WAKE: begin
          if (int'(r_s.wake) + 1 >= WAKEUP_CYCLES) begin
            r_s.state    <= S_RUN;
            r_s.req_pend <= 1'b1;
            r_s.timer    <= '0;
          end else
            r_s.wake <= r_s.wake + WW'(1);
        end
        S_RUN: begin
          // Advance beats a coincident timeout
          if (w_advance) begin
            r_s.pulse <= 1'b1;
            r_s.timer <= '0;
            if (w_last) begin
              // Flags left alone so a re-queued resp still drains in DONE
              r_s.state <= S_DONE;
              r_s.done  <= 1'b1;
            end else begin
              r_s.stage        <= r_s.stage + SW'(1);
              r_s.rx_req_seen  <= r_s.early_req || w_rx_nxt;
              r_s.resp_pend    <= r_s.early_req || w_rx_nxt;
              r_s.early_req    <= 1'b0;
              r_s.rx_resp_seen <= 1'b0;
              r_s.tx_resp_sent <= 1'b0;
              r_s.req_pend     <= 1'b1;
            end
          end else if (w_expire) begin
            if (w_retry) begin
              r_s.req_pend <= 1'b1;
              r_s.timer    <= '0;
            end else begin
              r_s.state    <= S_ERROR;
              r_s.err      <= 1'b1;
              r_s.tx_valid <= 1'b0;
            end
          end else
            r_s.timer <= r_s.timer + TW'(1);
        end
        default: ;
      endcase
    end
  end

  assign done_o                        = r_s.done;
  assign error_o                       = r_s.err;
  assign stage_o                       = r_s.stage;
  assign reset_state_timeout_counter_o = r_s.pulse;
  assign sb.SB_TX_msg_valid_o          = r_s.tx_valid;
  assign sb.SB_TX_msg_num_o            = r_s.tx_num;
  assign sb.SB_RX_msg_req_o            = r_s.rx_req;
endmodule

// File: tb/tb_ltsm_hs_sequencer.sv
// Directed bench for ltsm_hs_sequencer: a small link-partner model answers our
// reqs through an RX queue; a second instance with a short timeout is left
// silent to exercise the expiry path.
module tb_ltsm_hs_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       en = 1'b0, done, err, pulse;
  logic [2:0] stage;
  logic       en2 = 1'b0, done2, err2, pulse2;
  logic [2:0] stage2;

  ltsm_hs_sequencer_if #(.MSG_W(8)) sb ();
  ltsm_hs_sequencer_if #(.MSG_W(8)) sb2 ();

  ltsm_hs_sequencer #(.NUM_STAGES(6)) dut (
    .clk_100MHz(clk), .reset(rst), .enable_i(en), .done_o(done), .error_o(err),
    .stage_o(stage), .reset_state_timeout_counter_o(pulse), .sb(sb)
  );

  ltsm_hs_sequencer #(.NUM_STAGES(6), .TIMEOUT_CYCLES(16), .MAX_RETRIES(2)) dut2 (
    .clk_100MHz(clk), .reset(rst), .enable_i(en2), .done_o(done2), .error_o(err2),
    .stage_o(stage2), .reset_state_timeout_counter_o(pulse2), .sb(sb2)
  );

  int n_tests = 0, n_fail = 0;
  int cyc = 0;
  logic [7:0] rxq[$];
  logic [7:0] txlog[$];
  int rx_cnt[256];
  bit sent_req[16];
  bit auto_en = 1'b1;
  int early_s = -1;
  int pulses = 0;
  int stage_log[$];
  logic [2:0] last_stage = '0;
  int acc2[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int cnt_tx(input logic [7:0] c);
    int k = 0;
    foreach (txlog[i]) if (txlog[i] == c) k++;
    return k;
  endfunction

  // Partner: on our req(s) send its own req(s) (once) and resp(s);
  // in the early stage it also sends req(s+1) right behind.
  task automatic partner_tx(input logic [7:0] code);
    int s;
    if (!auto_en || code[0]) return;
    s = (int'(code) - 'h40) / 2;
    if (!sent_req[s]) begin rxq.push_back(code); sent_req[s] = 1'b1; end
    rxq.push_back(code + 8'd1);
    if (s == early_s) begin rxq.push_back(code + 8'd2); sent_req[s+1] = 1'b1; end
  endtask

  task automatic reset_model();
    rxq.delete(); txlog.delete(); stage_log.delete();
    foreach (rx_cnt[i]) rx_cnt[i] = 0;
    foreach (sent_req[i]) sent_req[i] = 1'b0;
    pulses = 0; last_stage = '0;
    sb.SB_RX_msg_valid_i = 1'b0;
    sb.SB_RX_msg_available_i = 1'b0;
  endtask

  // One clock: sample what the coming edge will see, then update the model
  task automatic tick();
    bit pop_now;
    if (sb.SB_TX_msg_valid_o && sb.SB_TX_msg_sendNextFlag_i) begin
      txlog.push_back(sb.SB_TX_msg_num_o);
      partner_tx(sb.SB_TX_msg_num_o);
    end
    if (sb2.SB_TX_msg_valid_o && sb2.SB_TX_msg_sendNextFlag_i) acc2.push_back(cyc);
    pop_now = sb.SB_RX_msg_req_o;
    @(posedge clk); #1;
    cyc++;
    sb.SB_RX_msg_valid_i = 1'b0;
    if (pop_now && rxq.size() > 0) begin
      sb.SB_RX_msg_valid_i = 1'b1;
      sb.SB_RX_msg_num_i   = rxq.pop_front();
      rx_cnt[sb.SB_RX_msg_num_i]++;
    end
    sb.SB_RX_msg_available_i = (rxq.size() > 0);
    if (pulse) pulses++;
    if (stage != last_stage) begin stage_log.push_back(int'(stage)); last_stage = stage; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] exp_e[7];
    bit ok;
    int c0, ferr;
    exp_e = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h47};
    sb.SB_TX_msg_sendNextFlag_i = 1'b1;
    sb.SB_RX_msg_num_i = '0; sb.SB_RX_msg_valid_i = 1'b0; sb.SB_RX_msg_available_i = 1'b0;
    sb2.SB_TX_msg_sendNextFlag_i = 1'b1;
    sb2.SB_RX_msg_num_i = '0; sb2.SB_RX_msg_valid_i = 1'b0; sb2.SB_RX_msg_available_i = 1'b0;
    tick(); tick();
    chk("rst_done", done, 0);  chk("rst_err", err, 0);  chk("rst_stage", stage, 0);
    chk("rst_valid", sb.SB_TX_msg_valid_o, 0); chk("rst_rxreq", sb.SB_RX_msg_req_o, 0);
    chk("rst_pulse", pulse, 0);
    rst = 1'b0; tick(); tick();
    chk("idle_valid", sb.SB_TX_msg_valid_o, 0);

    // Clean run: first req lands WAKEUP_CYCLES+1 edges after enable
    reset_model();
    en = 1'b1; tick(); tick(); tick();
    chk("wake_e2_valid", sb.SB_TX_msg_valid_o, 0);
    tick();
    chk("wake_e3_valid", sb.SB_TX_msg_valid_o, 1);
    chk("wake_e3_code", sb.SB_TX_msg_num_o, 8'h40);
    for (int n = 0; n < 1000 && !done; n++) tick();
    chk("clean_done", done, 1); chk("clean_err", err, 0);
    repeat (4) tick();
    chk("clean_pulses", pulses, 6); chk("clean_stage", stage, 5);
    chk("clean_nstage", stage_log.size(), 5);
    foreach (stage_log[i]) chk($sformatf("clean_stage%0d", i), stage_log[i], i + 1);
    chk("clean_ntx", txlog.size(), 12);
    foreach (txlog[i]) chk($sformatf("clean_tx%0d", i), txlog[i], 8'h40 + i);

    // Disable from DONE clears everything
    en = 1'b0; tick();
    chk("dis_done", done, 0); chk("dis_stage", stage, 0); chk("dis_valid", sb.SB_TX_msg_valid_o, 0);
    repeat (2) tick();

    // Crossed reqs: partner req(0) arrives while our req(0) is stalled
    reset_model();
    sb.SB_TX_msg_sendNextFlag_i = 1'b0; en = 1'b1;
    for (int n = 0; n < 20 && !(sb.SB_TX_msg_valid_o && sb.SB_TX_msg_num_o == 8'h40); n++) tick();
    chk("cross_offer", sb.SB_TX_msg_num_o, 8'h40);
    rxq.push_back(8'h40); sent_req[0] = 1'b1;
    for (int n = 0; n < 20 && rx_cnt[8'h40] == 0; n++) tick();
    chk("cross_rx40", rx_cnt[8'h40], 1);
    repeat (3) tick();
    chk("cross_hold_v", sb.SB_TX_msg_valid_o, 1); chk("cross_hold_c", sb.SB_TX_msg_num_o, 8'h40);
    sb.SB_TX_msg_sendNextFlag_i = 1'b1;
    for (int n = 0; n < 50 && stage == 0; n++) tick();
    chk("cross_adv", stage, 1);
    chk("cross_ntx", txlog.size(), 2);
    if (txlog.size() >= 2) begin
      chk("cross_tx0", txlog[0], 8'h40); chk("cross_tx1", txlog[1], 8'h41);
    end
    chk("cross_rx41", rx_cnt[8'h41], 1);

    // Backpressure on req(1): offer must hold steady for 10 cycles
    sb.SB_TX_msg_sendNextFlag_i = 1'b0;
    for (int n = 0; n < 10 && !sb.SB_TX_msg_valid_o; n++) tick();
    ok = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (!(sb.SB_TX_msg_valid_o && sb.SB_TX_msg_num_o == 8'h42)) ok = 1'b0;
      tick();
    end
    chk("bp_stable", ok, 1); chk("bp_code", sb.SB_TX_msg_num_o, 8'h42);

    // Early next req: resp(2), req(3) popped before our resp(2) is accepted
    early_s = 2; sb.SB_TX_msg_sendNextFlag_i = 1'b1;
    for (int n = 0; n < 100 && stage != 2; n++) tick();
    chk("early_st2", stage, 2);
    for (int n = 0; n < 50 && cnt_tx(8'h44) == 0; n++) tick();
    sb.SB_TX_msg_sendNextFlag_i = 1'b0;
    for (int n = 0; n < 50 && rx_cnt[8'h46] == 0; n++) tick();
    chk("early_rx46", rx_cnt[8'h46], 1);
    tick();
    chk("early_hold_st", stage, 2);
    sb.SB_TX_msg_sendNextFlag_i = 1'b1;
    for (int n = 0; n < 50 && stage != 3; n++) tick();
    chk("early_st3", stage, 3);
    for (int n = 0; n < 50 && cnt_tx(8'h47) == 0; n++) tick();
    sb.SB_TX_msg_sendNextFlag_i = 1'b0;
    chk("early_tx47", cnt_tx(8'h47), 1);
    chk("early_no_rereq", rx_cnt[8'h46], 1);
    chk("seq_ntx", txlog.size(), 7);
    foreach (txlog[i]) if (i < 7) chk($sformatf("seq_tx%0d", i), txlog[i], exp_e[i]);

    // Abort at stage 3, then restart
    repeat (2) tick();
    chk("abort_pre_st", stage, 3);
    en = 1'b0; tick();
    chk("abort_valid", sb.SB_TX_msg_valid_o, 0); chk("abort_stage", stage, 0); chk("abort_done", done, 0);
    repeat (2) tick();
    reset_model(); early_s = -1; sb.SB_TX_msg_sendNextFlag_i = 1'b1;
    en = 1'b1; tick(); tick(); tick();
    chk("restart_e2_valid", sb.SB_TX_msg_valid_o, 0);
    tick();
    chk("restart_e3_valid", sb.SB_TX_msg_valid_o, 1);
    chk("restart_e3_code", sb.SB_TX_msg_num_o, 8'h40);

    // Silent partner on the short-timeout instance
    en2 = 1'b1; tick(); c0 = cyc; ferr = -1;
    for (int t = 0; t < 70; t++) begin
      if (err2 && ferr < 0) ferr = t;
      tick();
    end
`ifdef LTSM_HS_RETRY_EN
    chk("to_err_at", ferr, 50);
    chk("to_nreq", acc2.size(), 3);
    if (acc2.size() == 3) begin
      chk("to_req0", acc2[0] - c0, 3); chk("to_req1", acc2[1] - c0, 19); chk("to_req2", acc2[2] - c0, 35);
    end
`else
    chk("to_err_at", ferr, 18);
    chk("to_nreq", acc2.size(), 1);
    if (acc2.size() == 1) chk("to_req0", acc2[0] - c0, 3);
`endif
    chk("to_valid_off", sb2.SB_TX_msg_valid_o, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
